// File: rtl/sevenseg_pkg.sv
// Shared constants for the two-digit multiplexed seven-segment interface.
// Segment codes are active-low, bit order g..a; digit enables are active-low.
package sevenseg_pkg;

  localparam int DIG_W = 6;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [DIG_W-1:0] DIG_TENS = 6'b101111;
  localparam logic [DIG_W-1:0] DIG_ONES = 6'b011111;
  localparam logic [DIG_W-1:0] DIG_NONE = 6'b111111;

  // Shift-and-add form keeps the multiply out of the datapath; t is 0..9.
  function automatic logic [6:0] times10(input logic [3:0] t);
    logic [6:0] w;
    w = {3'b000, t};
    return (w << 3) + (w << 1);
  endfunction

  function automatic logic [6:0] frame_value(input logic [3:0] tens,
                                             input logic [3:0] ones);
    return times10(tens) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational decode of an active-low seven-segment pattern to a BCD digit.
// o_legal is low for any pattern that is not one of the ten digit codes.
module seg_to_bcd
  import sevenseg_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic [3:0]       o_digit,
  output logic             o_legal
);

  always_comb begin
    o_digit = 4'd0;
    o_legal = 1'b1;
    case (i_seg)
      SEG_0:   o_digit = 4'd0;
      SEG_1:   o_digit = 4'd1;
      SEG_2:   o_digit = 4'd2;
      SEG_3:   o_digit = 4'd3;
      SEG_4:   o_digit = 4'd4;
      SEG_5:   o_digit = 4'd5;
      SEG_6:   o_digit = 4'd6;
      SEG_7:   o_digit = 4'd7;
      SEG_8:   o_digit = 4'd8;
      SEG_9:   o_digit = 4'd9;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Recovers the two-digit value shown on a multiplexed seven-segment display by
// tapping its dig/disp nets; strobes value_valid once per complete tens+ones frame.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TENS_IDX      = 4,
  parameter int ONES_IDX      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEG_W-1:0] disp,
  input  logic [DIG_W-1:0] dig,
  output logic [6:0]       value,
  output logic             value_valid,
  output logic [3:0]       tens_digit,
  output logic [3:0]       ones_digit,
  output logic             err
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("STABLE_CYCLES must be in 1..255");
  end
  if (TENS_IDX == ONES_IDX || TENS_IDX >= DIG_W || ONES_IDX >= DIG_W) begin : g_bad_idx
    $error("TENS_IDX/ONES_IDX must be distinct bits of dig");
  end

  localparam logic [7:0]       CNT_MAX  = 8'(STABLE_CYCLES - 1);
  localparam logic [DIG_W-1:0] SEL_TENS = DIG_W'(1) << TENS_IDX;
  localparam logic [DIG_W-1:0] SEL_ONES = DIG_W'(1) << ONES_IDX;

  logic [DIG_W-1:0] r_dig_p0, r_dig_p1, r_dig_p2;
  logic [SEG_W-1:0] r_disp_p0, r_disp_p1, r_disp_p2;
  logic [7:0]       r_cnt_p2;
  logic             r_armed_p2;

  logic [6:0]       r_value;
  logic             r_valid;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic             r_tens_cap;
  logic             r_ones_cap;
  logic             r_err;

  logic             w_accept;
  logic [DIG_W-1:0] w_low;
  logic             w_multi;
  logic             w_sel_tens;
  logic             w_sel_ones;
  logic [3:0]       w_digit;
  logic             w_legal;

  // Stage p0/p1: two-flop synchronizer; reset to the blank (idle) level so
  // release never looks like a fresh pattern.
  // Stage p2: held pair plus stability counter; armed marks a not-yet-accepted run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dig_p0   <= DIG_NONE;
      r_dig_p1   <= DIG_NONE;
      r_disp_p0  <= SEG_BLANK;
      r_disp_p1  <= SEG_BLANK;
      r_dig_p2   <= DIG_NONE;
      r_disp_p2  <= SEG_BLANK;
      r_cnt_p2   <= 8'd0;
      r_armed_p2 <= 1'b0;
    end else begin
      r_dig_p0  <= dig;
      r_dig_p1  <= r_dig_p0;
      r_disp_p0 <= disp;
      r_disp_p1 <= r_disp_p0;
      if ({r_dig_p1, r_disp_p1} != {r_dig_p2, r_disp_p2}) begin
        r_dig_p2   <= r_dig_p1;
        r_disp_p2  <= r_disp_p1;
        r_cnt_p2   <= 8'd0;
        r_armed_p2 <= 1'b1;
      end else begin
        if (r_cnt_p2 != CNT_MAX) begin
          r_cnt_p2 <= r_cnt_p2 + 8'd1;
        end
        if (w_accept) begin
          r_armed_p2 <= 1'b0;
        end
      end
    end
  end

  assign w_accept   = r_armed_p2 && (r_cnt_p2 == CNT_MAX);
  assign w_low      = ~r_dig_p2;
  assign w_multi    = |(w_low & (w_low - DIG_W'(1)));
  assign w_sel_tens = (w_low == SEL_TENS);
  assign w_sel_ones = (w_low == SEL_ONES);

  seg_to_bcd u_seg_to_bcd (
    .i_seg   (r_disp_p2),
    .o_digit (w_digit),
    .o_legal (w_legal)
  );

  // Stage p3: classify the accepted pair; the frame completes on the accept
  // that sets the second capture flag, using the digit arriving on that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value    <= 7'd0;
      r_valid    <= 1'b0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_tens_cap <= 1'b0;
      r_ones_cap <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_accept) begin
        if (w_multi) begin
          r_err <= 1'b1;
        end else if (w_sel_tens) begin
          if (!w_legal) begin
            r_err <= 1'b1;
          end else begin
            r_tens <= w_digit;
            if (r_ones_cap) begin
              r_value    <= frame_value(w_digit, r_ones);
              r_valid    <= 1'b1;
              r_tens_cap <= 1'b0;
              r_ones_cap <= 1'b0;
            end else begin
              r_tens_cap <= 1'b1;
            end
          end
        end else if (w_sel_ones) begin
          if (!w_legal) begin
            r_err <= 1'b1;
          end else begin
            r_ones <= w_digit;
            if (r_tens_cap) begin
              r_value    <= frame_value(r_tens, w_digit);
              r_valid    <= 1'b1;
              r_tens_cap <= 1'b0;
              r_ones_cap <= 1'b0;
            end else begin
              r_ones_cap <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign value       = r_value;
  assign value_valid = r_valid;
  assign tens_digit  = r_tens;
  assign ones_digit  = r_ones;
  assign err         = r_err;

endmodule
